// File: rtl/nios_project_button_debounce.sv
// rtl/nios_project_button_debounce.sv - per-channel button synchronizer and debouncer
//
// Purpose: two-flop synchronizer, optional inversion, and a two-state
// debounce FSM per channel. It produces clean active-high levels for the
// Nios button PIO and, optionally, single-cycle press/release pulses.
//
// Configuration macro: BUTTON_DEBOUNCE_EDGE_EN
//   defined   - press_pulse/release_pulse are registered and coincide with
//               the new btn_out value
//   undefined - the edge registers are absent and both pulse outputs are 0
//
// Ports:
//   clk            system clock (PIO domain)
//   reset          asynchronous, active-high reset
//   btn_raw        raw asynchronous button pins
//   btn_out        debounced level, 1 = pressed
//   press_pulse    one-cycle pulse when btn_out[i] rises
//   release_pulse  one-cycle pulse when btn_out[i] falls
module nios_project_button_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

  // Released pin level; also the XOR mask that turns s2 into an active-high level.
  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            s2_q;
  logic [WIDTH-1:0]            lvl;
  logic [WIDTH-1:0]            state_q, state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            btn_q, btn_d;
  logic [WIDTH-1:0]            fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= {WIDTH{IDLE}};
      s2_q <= {WIDTH{IDLE}};
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  assign lvl = s2_q ^ {WIDTH{IDLE}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (lvl[i] != btn_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = ONE;
          end
        end
        ST_COUNT: begin
          // Bounce check wins over the terminal compare.
          if (lvl[i] == btn_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == TERM) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
            fire[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign btn_d = btn_q ^ fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= {WIDTH{ST_STABLE}};
      cnt_q   <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
    end
  end

  assign btn_out = btn_q;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;

  // Registered alongside btn_q so each pulse lines up with the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= fire & btn_d;
      release_q <= fire & ~btn_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`else
  assign press_pulse   = '0;
  assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_nios_project_button_debounce.sv
// tb/tb_nios_project_button_debounce.sv - scoreboard bench for the button debouncer
module tb_nios_project_button_debounce;

  localparam int D = 8;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  localparam logic [1:0] PM = 2'b11;
`else
  localparam logic [1:0] PM = 2'b00;
`endif

  typedef struct {
    string      tag;
    logic [5:0] v;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  nios_project_button_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_out(btn_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int n, input logic [1:0] o,
                      input logic [1:0] pr, input logic [1:0] rl);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.tag = tag;
      it.v   = {o, pr & PM, rl & PM};
      sb.push_back(it);
    end
  endtask

  task automatic step(input int n);
    item_t      it;
    logic [5:0] obs;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = {btn_out, press_pulse, release_pulse};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL sb_empty observed=%b", obs);
      end else begin
        it = sb.pop_front();
        assert (obs === it.v) else begin
          bad++;
          $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.v);
        end
      end
    end
  endtask

  // Raw change just after an edge; the accepted level shows on the 10th edge.
  task automatic accept(input string tag, input logic [1:0] raw,
                        input logic [1:0] old_o, input logic [1:0] new_o,
                        input logic [1:0] pr, input logic [1:0] rl);
    btn_raw = raw;
    push(tag, D + 1, old_o, 2'b00, 2'b00);
    push(tag, 1, new_o, pr, rl);
    push(tag, 2, new_o, 2'b00, 2'b00);
    step(D + 4);
  endtask

  initial begin
    // Reset with buttons released, then idle.
    push("in_reset", 3, 2'b00, 2'b00, 2'b00);
    step(3);
    reset = 1'b0;
    push("idle", 20, 2'b00, 2'b00, 2'b00);
    step(20);

    // Press channel 0 only.
    accept("press0", 2'b10, 2'b00, 2'b01, 2'b01, 2'b00);

    // Release glitch of D-1 cycles is rejected.
    btn_raw = 2'b11;
    push("glitch", D - 1, 2'b01, 2'b00, 2'b00);
    step(D - 1);
    btn_raw = 2'b10;
    push("glitch", 12, 2'b01, 2'b00, 2'b00);
    step(12);

    // Release, then a bounce train ending steady pressed.
    accept("release0", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01);
    for (int s = 0; s < 10; s++) begin
      btn_raw = (s % 2 == 0) ? 2'b10 : 2'b11;
      push("bounce", 3, 2'b00, 2'b00, 2'b00);
      step(3);
    end
    accept("bounce_press", 2'b10, 2'b00, 2'b01, 2'b01, 2'b00);

    // Both channels at once.
    accept("release0b", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01);
    accept("press_both", 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    accept("release_both", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

    // Reset at count 5 during a press, button held through reset.
    btn_raw = 2'b00;
    push("pre_reset", 7, 2'b00, 2'b00, 2'b00);
    step(7);
    total++;
    assert (dut.cnt_q[0] === 3'd5 && dut.cnt_q[1] === 3'd5) else begin
      bad++;
      $error("FAIL count5 observed=%0d/%0d expected=5/5", dut.cnt_q[0], dut.cnt_q[1]);
    end
    reset = 1'b1;
    #1;
    total++;
    assert ({btn_out, press_pulse, release_pulse, dut.cnt_q} === 12'd0) else begin
      bad++;
      $error("FAIL reset_now observed=%b expected=0", {btn_out, press_pulse, release_pulse, dut.cnt_q});
    end
    push("mid_reset", 3, 2'b00, 2'b00, 2'b00);
    step(3);
    reset = 1'b0;
    push("post_reset", D + 1, 2'b00, 2'b00, 2'b00);
    push("post_reset", 1, 2'b11, 2'b11, 2'b00);
    push("post_reset", 2, 2'b11, 2'b00, 2'b00);
    step(D + 4);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_project_button_debounce.md
# nios_project_button_debounce

Per-channel synchronizer and debouncer for the board push-buttons. It sits directly upstream of the Nios button PIO and drives its 2-bit `in_port` with clean, glitch-free, active-high levels. It also produces single-cycle press and release pulses for fabric logic that needs edges rather than levels.

## Interface
- `WIDTH`, default 2: number of button channels; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive clock cycles a new level must hold before it is accepted (1 ms at 50 MHz). Must be ≥ 2.
- `ACTIVE_LOW`, default 1: when 1, the raw input is inverted after synchronization, so that `btn_out` = 1 means pressed.
- `clk`  input  1  system clock, same domain as the PIO.
- `reset`  input  1  asynchronous, active-high reset.
- `btn_raw`  input  WIDTH  raw, asynchronous button pins.
- `btn_out`  output  WIDTH  debounced level, active-high pressed; connects to PIO `in_port`.
- `press_pulse`  output  WIDTH  one-cycle pulse when `btn_out[i]` rises.
- `release_pulse`  output  WIDTH  one-cycle pulse when `btn_out[i]` falls.

## Operation
- Each channel is independent and uses identical logic. Channels share only `clk` and `reset`.
- Synchronizer: two flip-flops per channel (`s1`, then `s2`). If `ACTIVE_LOW` is set, the inversion is applied at the `s2` output, giving the signal `lvl`.
- Counter: `CNT_W = $clog2(DEBOUNCE_CYCLES)` bits, unsigned, one per channel.
- Per-channel FSM has two states:
  - STABLE: `lvl == btn_out[i]`. The counter is held at 0. If `lvl != btn_out[i]`, go to COUNT and set the counter to 1.
  - COUNT: the counter increments each cycle while `lvl != btn_out[i]`.
    - If `lvl == btn_out[i]` at any cycle (bounce), clear the counter to 0 and return to STABLE. `btn_out` does not change.
    - When the counter equals `DEBOUNCE_CYCLES-1` and `lvl` still differs, do all of the following on the next edge: toggle `btn_out[i]`, clear the counter, return to STABLE, and pulse `press_pulse[i]` or `release_pulse[i]` according to the new level.
- The counter never wraps, because it is bounded by the terminal compare.
- Reset values:
  - `s1` and `s2` are loaded with the idle (released) pin level: 1 if `ACTIVE_LOW`, else 0.
  - `btn_out` = 0, all counters = 0, all FSMs in STABLE, `press_pulse` = 0, `release_pulse` = 0.
- Reset asserted mid-count immediately forces all of the reset values above. There are no spurious pulses on reset deassertion.
- A button held through reset is debounced fresh after release of reset. A press pulse follows the full latency.

## Timing
- Let the raw edge settle before clock edge 0. Then:
  - `s1` updates at edge 1 and `s2` at edge 2.
  - `btn_out` changes at edge `2 + DEBOUNCE_CYCLES`.
  - The pulse is high for exactly the cycle after that edge, i.e. it is registered and coincident with the new `btn_out` value.
- Minimum accepted stable width is `DEBOUNCE_CYCLES` consecutive cycles of `lvl`. A glitch of `DEBOUNCE_CYCLES-1` cycles or shorter is fully rejected.
- All outputs are registered. There is no combinational path from `btn_raw` to any output.
- `press_pulse[i]` and `release_pulse[i]` are never high in the same cycle. Each is high for at most one cycle per transition.

## Configuration
- `BUTTON_DEBOUNCE_EDGE_EN` defined:
  - `press_pulse` and `release_pulse` are generated from registered edge detection on `btn_out`, as described above.
- Not defined:
  - The edge-detect registers are not instantiated.
  - `press_pulse` and `release_pulse` are tied to 0.
  - `btn_out` behaviour is identical in both builds.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 8, `WIDTH` = 2, `ACTIVE_LOW` = 1.
- Reset with `btn_raw` = 2'b11 and hold for 20 cycles -> `btn_out` = 2'b00 and no pulses throughout.
- Drive `btn_raw[0]` to 0 at cycle 0 and hold -> `btn_out[0]` goes to 1 at edge 10; `press_pulse[0]` is high for 1 cycle; channel 1 is unchanged.
- From the pressed state, drive `btn_raw[0]` to 1 for 7 cycles, then back to 0 -> `btn_out[0]` stays 1 and no `release_pulse`.
- Bounce train of 0/1 toggling every 3 cycles for 30 cycles, then steady 0 -> exactly one `press_pulse`, 10 cycles after the last toggle.
- Toggle both channels in the same cycle -> `btn_out` = 2'b11 at edge 10 and both `press_pulse` bits high in the same cycle.
- Assert `reset` at count 5 during a press -> `btn_out` = 0 and counters = 0 immediately. After deassertion with the button still held, a press is accepted 10 cycles later.
- With `BUTTON_DEBOUNCE_EDGE_EN` undefined, rerun the second scenario -> `btn_out` timing is identical and the pulses remain 0.
